// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS R-type control constants: function codes, ALU select encodings, FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SLL = 3'b011;
    localparam logic [2:0] SEL_SRL = 3'b100;
    localparam logic [2:0] SEL_NOR = 3'b101;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DECODE    = 2'd1;
    localparam logic [1:0] ST_EXECUTE   = 2'd2;
    localparam logic [1:0] ST_WRITEBACK = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, ALU control and status bundle of the multicycle control unit.
interface multicycle_control_unit_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [5:0]       opcode;
    logic [5:0]       function_code;
    logic             alu_done;
    logic [SEL_W-1:0] select_bits_ALU;
    logic             ir_write;
    logic             alu_start;
    logic             reg_write;
    logic             pc_write;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output instr_valid, opcode, function_code, alu_done,
        input  instr_ready, select_bits_ALU, ir_write, alu_start, reg_write,
               pc_write, illegal, busy, retired_cnt, illegal_cnt
    );

    modport slave (
        input  instr_valid, opcode, function_code, alu_done,
        output instr_ready, select_bits_ALU, ir_write, alu_start, reg_write,
               pc_write, illegal, busy, retired_cnt, illegal_cnt
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational R-type decoder, shared with the single-cycle datapath.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int SHIFT_EN = 1
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       function_code,
    output logic [SEL_W-1:0] select,
    output logic             legal
);
    logic [2:0] sel3;
    logic       known;

    always_comb begin
        sel3  = SEL_AND;
        known = 1'b1;
        case (function_code)
            FN_ADD, FN_ADDU: sel3 = SEL_ADD;
            FN_SUB, FN_SUBU: sel3 = SEL_SUB;
            FN_AND:          sel3 = SEL_AND;
            FN_OR:           sel3 = SEL_OR;
            FN_NOR:          sel3 = SEL_NOR;
            FN_SLT, FN_SLTU: sel3 = SEL_SLT;
            FN_SLL: begin
                sel3  = SEL_SLL;
                known = (SHIFT_EN != 0);
            end
            FN_SRL: begin
                sel3  = SEL_SRL;
                known = (SHIFT_EN != 0);
            end
            default:         known = 1'b0;
        endcase
        legal       = known && (opcode == OP_RTYPE);
        select      = '0;
        select[2:0] = sel3;
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Four-state multicycle control for R-type instructions with retired/illegal counters.
//   state        | meaning
//   ST_IDLE      | ready for an instruction; latches opcode/function on instr_valid
//   ST_DECODE    | legal: load select, pulse alu_start; illegal: pulse illegal, back to idle
//   ST_EXECUTE   | hold select, wait (unbounded) for alu_done
//   ST_WRITEBACK | pulse reg_write + pc_write, count the retirement
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int SHIFT_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.slave  bus
);
    logic [1:0]       state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       funct_q, funct_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [SEL_W-1:0] dec_select;
    logic             dec_legal;
    logic             ir_write, alu_start, wb_strobe, illegal_pulse;

    alu_decoder #(.SEL_W(SEL_W), .SHIFT_EN(SHIFT_EN)) u_dec (
        .opcode        (opcode_q),
        .function_code (funct_q),
        .select        (dec_select),
        .legal         (dec_legal)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        funct_d       = funct_q;
        select_d      = select_q;
        retired_d     = retired_q;
        illegal_cnt_d = illegal_cnt_q;
        ir_write      = 1'b0;
        alu_start     = 1'b0;
        wb_strobe     = 1'b0;
        illegal_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    ir_write = 1'b1;
                    opcode_d = bus.opcode;
                    funct_d  = bus.function_code;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    select_d  = dec_select;
                    alu_start = 1'b1;
                    state_d   = ST_EXECUTE;
                end else begin
                    illegal_pulse = 1'b1;
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                    state_d       = ST_IDLE;
                end
            end
            // alu_done is only looked at here, so a done in the launch cycle is ignored
            ST_EXECUTE: begin
                if (bus.alu_done) state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                wb_strobe = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            opcode_q      <= '0;
            funct_q       <= '0;
            select_q      <= '0;
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            funct_q       <= funct_d;
            select_q      <= select_d;
            retired_q     <= retired_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Strobes are gated by rst_n so an aborted writeback never escapes during reset
    assign bus.instr_ready     = rst_n && (state_q == ST_IDLE);
    assign bus.ir_write        = rst_n && ir_write;
    assign bus.alu_start       = rst_n && alu_start;
    assign bus.reg_write       = rst_n && wb_strobe;
    assign bus.pc_write        = rst_n && wb_strobe;
    assign bus.illegal         = rst_n && illegal_pulse;
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.select_bits_ALU = select_q;
    assign bus.retired_cnt     = retired_q;
    assign bus.illegal_cnt     = illegal_cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: three DUT configurations, directed instructions, monitor-side checking.
module tb_multicycle_control_unit;
    typedef struct {
        bit ill;
        int sel;
        int cnt;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] done;
    logic [5:0] op [3];
    logic [5:0] fn [3];
    exp_t       exp_q [3][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // g0: defaults; g1: SHIFT_EN=0 with a wider select; g2: 2-bit counters
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SW = (g == 1) ? 5 : 3;
        localparam int SE = (g == 1) ? 0 : 1;
        localparam int CW = (g == 2) ? 2 : 16;

        multicycle_control_unit_if #(.SEL_W(SW), .CNT_W(CW)) bus ();

        assign bus.instr_valid   = valid[g];
        assign bus.opcode        = op[g];
        assign bus.function_code = fn[g];
        assign bus.alu_done      = done[g];

        multicycle_control_unit #(.SEL_W(SW), .SHIFT_EN(SE), .CNT_W(CW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        int   acc_cyc = 0;
        bit   in_exec = 0;
        bit   sel_ok  = 0;
        bit   pend    = 0;
        exp_t e;

        always @(negedge clk) begin
            if (!rst_n) begin
                in_exec = 0;
                pend    = 0;
            end else begin
                if (pend) begin
                    pend = 0;
                    check($sformatf("g%0d counter", g),
                          e.ill ? 32'(bus.illegal_cnt) : 32'(bus.retired_cnt), e.cnt);
                    check($sformatf("g%0d idle_after", g), 32'(bus.busy), 0);
                end
                if (bus.ir_write) acc_cyc = cyc;
                if (in_exec && !bus.alu_start && exp_q[g].size() > 0 &&
                    32'(bus.select_bits_ALU) != exp_q[g][0].sel)
                    sel_ok = 0;
                if (bus.alu_start) begin
                    in_exec = 1;
                    sel_ok  = 1;
                end
                if (bus.reg_write || bus.pc_write || bus.illegal) begin
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL g%0d unexpected_completion: got rw=%0b pw=%0b ill=%0b expected none",
                                 g, bus.reg_write, bus.pc_write, bus.illegal);
                    end else begin
                        e    = exp_q[g].pop_front();
                        pend = 1;
                        check($sformatf("g%0d illegal", g), 32'(bus.illegal), 32'(e.ill));
                        check($sformatf("g%0d reg_write", g), 32'(bus.reg_write), 32'(!e.ill));
                        check($sformatf("g%0d pc_write", g), 32'(bus.pc_write), 32'(!e.ill));
                        check($sformatf("g%0d alu_start", g), 32'(bus.alu_start), 0);
                        check($sformatf("g%0d select", g), 32'(bus.select_bits_ALU), e.sel);
                        check($sformatf("g%0d latency", g), cyc - acc_cyc + 1, e.lat);
                        if (!e.ill) check($sformatf("g%0d select_held", g), 32'(sel_ok), 1);
                        in_exec = 0;
                    end
                end
            end
        end
    end

    // d = cycles from alu_start to alu_done; early drives alu_done in the alu_start cycle
    task automatic issue(int g, logic [5:0] o, logic [5:0] f, int d, bit early,
                         bit ill, int sel, int cnt, int lat);
        exp_t x;
        x.ill = ill;
        x.sel = sel;
        x.cnt = cnt;
        x.lat = lat;
        exp_q[g].push_back(x);
        @(posedge clk); #1;
        valid[g] = 1'b1;
        op[g]    = o;
        fn[g]    = f;
        @(posedge clk); #1;
        valid[g] = 1'b0;
        op[g]    = 6'b111111;
        if (ill) begin
            @(posedge clk); #1;
        end else begin
            done[g] = early;
            repeat (d) begin
                @(posedge clk); #1;
                done[g] = 1'b0;
            end
            done[g] = 1'b1;
            @(posedge clk); #1;
            done[g] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        done  = '0;
        for (int i = 0; i < 3; i++) begin
            op[i] = '0;
            fn[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset instr_ready", 32'(g_dut[0].bus.instr_ready), 0);
        check("reset busy", 32'(g_dut[0].bus.busy), 0);
        check("reset select", 32'(g_dut[0].bus.select_bits_ALU), 0);
        check("reset retired", 32'(g_dut[0].bus.retired_cnt), 0);
        check("reset illegal_cnt", 32'(g_dut[2].bus.illegal_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("release instr_ready", 32'(g_dut[0].bus.instr_ready), 1);

        // Abort mid-EXECUTE: add accepted, two EXECUTE cycles without alu_done, then reset
        @(posedge clk); #1;
        valid[0] = 1'b1;
        fn[0]    = 6'b100000;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("exec busy", 32'(g_dut[0].bus.busy), 1);
        check("exec select", 32'(g_dut[0].bus.select_bits_ALU), 2);
        rst_n = 1'b0;
        #1;
        check("abort reg_write", 32'(g_dut[0].bus.reg_write), 0);
        check("abort instr_ready", 32'(g_dut[0].bus.instr_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort ready_after", 32'(g_dut[0].bus.instr_ready), 1);
        check("abort busy_after", 32'(g_dut[0].bus.busy), 0);
        check("abort retired", 32'(g_dut[0].bus.retired_cnt), 0);
        check("abort illegal_cnt", 32'(g_dut[0].bus.illegal_cnt), 0);
        check("abort select", 32'(g_dut[0].bus.select_bits_ALU), 0);

        // alu_done while idle must not start anything
        done[0] = 1'b1;
        @(posedge clk); #1;
        done[0] = 1'b0;
        check("idle alu_done busy", 32'(g_dut[0].bus.busy), 0);
        check("idle alu_done retired", 32'(g_dut[0].bus.retired_cnt), 0);

        //     g  opcode     funct      d  early ill sel cnt lat
        issue(0, 6'b000000, 6'b100000, 1, 0,    0,  2,  1,  4);
        issue(0, 6'b000000, 6'b100111, 5, 1,    0,  5,  2,  8);
        issue(0, 6'b001000, 6'b100000, 0, 0,    1,  5,  1,  2);
        issue(0, 6'b000000, 6'b000011, 0, 0,    1,  5,  2,  2);
        issue(0, 6'b000000, 6'b000010, 2, 0,    0,  4,  3,  5);
        issue(0, 6'b000000, 6'b100010, 1, 0,    0,  6,  4,  4);
        issue(0, 6'b000000, 6'b101011, 1, 0,    0,  7,  5,  4);
        issue(0, 6'b000000, 6'b100101, 1, 0,    0,  1,  6,  4);
        issue(0, 6'b000000, 6'b100100, 1, 0,    0,  0,  7,  4);
        issue(0, 6'b000000, 6'b000000, 1, 0,    0,  3,  8,  4);

        issue(1, 6'b000000, 6'b000010, 0, 0,    1,  0,  1,  2);
        issue(1, 6'b000000, 6'b000000, 0, 0,    1,  0,  2,  2);
        issue(1, 6'b000000, 6'b100001, 1, 0,    0,  2,  1,  4);
        issue(1, 6'b000000, 6'b000010, 0, 0,    1,  2,  3,  2);

        issue(2, 6'b000000, 6'b100000, 1, 0,    0,  2,  1,  4);
        issue(2, 6'b000000, 6'b100011, 1, 0,    0,  6,  2,  4);
        issue(2, 6'b000000, 6'b100100, 1, 0,    0,  0,  3,  4);
        issue(2, 6'b000000, 6'b100101, 1, 0,    0,  1,  0,  4);
        issue(2, 6'b000000, 6'b100111, 1, 0,    0,  5,  1,  4);

        repeat (3) @(posedge clk);
        #1;
        check("g0 drained", exp_q[0].size(), 0);
        check("g1 drained", exp_q[1].size(), 0);
        check("g2 drained", exp_q[2].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL expose parameter SEL_W, default 3, meaning ALU select width; legal values are 3 to 8.
REQ-002 The block SHALL expose parameter SHIFT_EN, default 1; when 1, sll/srl are legal, and when 0, sll/srl are illegal.
REQ-003 The block SHALL expose parameter CNT_W, default 16, meaning the width of the retired and illegal counters.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-low:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted this cycle
- opcode  in  6  instruction bits 31:26
- function_code  in  6  instruction bits 5:0
- alu_done  in  1  ALU result valid
- select_bits_ALU  out  SEL_W  ALU operation select
- ir_write  out  1  latch instruction register
- alu_start  out  1  one-cycle ALU launch pulse
- reg_write  out  1  register-file write strobe
- pc_write  out  1  PC increment strobe
- illegal  out  1  one-cycle illegal-instruction pulse
- busy  out  1  FSM not in IDLE
- retired_cnt  out  CNT_W  legal instructions completed
- illegal_cnt  out  CNT_W  illegal instructions rejected

Function
REQ-005 The FSM SHALL have the states IDLE, DECODE, EXECUTE, WRITEBACK.
REQ-006 In IDLE, instr_ready SHALL be 1; on instr_valid=1, ir_write SHALL pulse in that cycle, the opcode and function_code SHALL be registered, and the FSM SHALL go to DECODE.
REQ-007 Outside IDLE, instr_ready SHALL be 0 and instr_valid SHALL be ignored.
REQ-008 DECODE SHALL last one cycle; with a legal instruction, select_bits_ALU SHALL be registered, alu_start SHALL pulse for one cycle, and the FSM SHALL go to EXECUTE.
REQ-009 Decode map, zero-extended to SEL_W, SHALL be:
- add 100000 / addu 100001 -> 010
- sub 100010 / subu 100011 -> 110
- and 100100 -> 000
- or 100101 -> 001
- nor 100111 -> 101
- slt 101010 / sltu 101011 -> 111
- sll 000000 -> 011
- srl 000010 -> 100
REQ-010 An instruction SHALL be illegal if opcode≠000000, if function_code is absent from REQ-009, or if it is a shift with SHIFT_EN=0.
REQ-011 For an illegal instruction, DECODE SHALL pulse illegal for one cycle, increment illegal_cnt, hold select_bits_ALU, assert no alu_start/reg_write/pc_write, and return to IDLE.
REQ-012 EXECUTE SHALL hold select_bits_ALU stable and wait for alu_done for an unbounded number of cycles; alu_done sampled in the alu_start cycle SHALL be ignored.
REQ-013 On alu_done=1 in EXECUTE, the FSM SHALL go to WRITEBACK.
REQ-014 WRITEBACK SHALL last one cycle, pulse reg_write and pc_write together, increment retired_cnt, and return to IDLE.
REQ-015 Minimum latency SHALL be 4 cycles from acceptance to return to IDLE: accept, DECODE, EXECUTE with alu_done=1, WRITEBACK.
REQ-016 Both counters SHALL wrap from all-ones to 0 without a flag.
REQ-017 busy SHALL equal (state≠IDLE).
REQ-018 alu_done outside EXECUTE SHALL have no effect.

Reset
REQ-019 When rst_n=0 at a clk edge, the FSM SHALL go to IDLE and select_bits_ALU, both counters and all strobes SHALL become 0.
REQ-020 rst_n=0 in any state, including mid-EXECUTE, SHALL abort the instruction with no reg_write, no pc_write and no counter change.
REQ-021 During reset, instr_ready SHALL be 0; it SHALL be 1 from the first cycle after rst_n returns to 1.

Structure
REQ-022 Function-code constants, the select encodings and the state enumeration SHALL reside in shared package mips_ctrl_pkg.
REQ-023 Decode SHALL be a combinational sub-module alu_decoder (function_code, opcode, SHIFT_EN -> select, legal), reused by the single-cycle path.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- add (op 000000, fn 100000), alu_done 1 cycle after alu_start -> select 010, reg_write and pc_write pulse together, retired_cnt=1, 4 cycles total.
- fn 100111 with alu_done delayed 5 cycles -> select 101 held stable throughout EXECUTE, single reg_write.
- op 001000 or fn 000011 -> illegal pulse, illegal_cnt=1, no reg_write, back in IDLE after 2 cycles.
- SHIFT_EN=0, fn 000010 -> illegal; SHIFT_EN=1 -> select 100.
- rst_n=0 during EXECUTE -> no reg_write, counters unchanged, instr_ready=1 the cycle after release.
- CNT_W=2, 5 legal instructions -> retired_cnt wraps to 1.
